// File: rtl/mem_bus_arbiter.sv
// Arbitrates one single-port memory bus between instruction fetch and load/store,
// holding returned data and raising per-port stall requests until the data is ready.
module mem_bus_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        Rst_n,
    input  logic [5:0]  stall_i,
    input  logic        flush_i,
    input  logic        if_ce_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_stallreq_o,
    input  logic        mem_ce_i,
    input  logic        mem_we_i,
    input  logic [3:0]  mem_sel_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_stallreq_o,
    output logic        bus_cyc_o,
    output logic        bus_stb_o,
    output logic        bus_we_o,
    output logic [3:0]  bus_sel_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_data_o,
    input  logic [31:0] bus_data_i,
    input  logic        bus_ack_i,
    output logic        bus_err_o
);

    localparam int unsigned   CW       = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic          OWN_IF   = 1'b0;
    localparam logic          OWN_MEM  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic           owner_q, owner_d;
    logic           discard_q, discard_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [31:0]    rd_buf_q, rd_buf_d;
    logic           cyc_q, cyc_d;
    logic           stb_q, stb_d;
    logic           we_q, we_d;
    logic [3:0]     sel_q, sel_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic           err_q, err_d;
    logic           drop_s;

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        discard_d = discard_q;
        cnt_d     = cnt_q;
        rd_buf_d  = rd_buf_q;
        cyc_d     = cyc_q;
        stb_d     = stb_q;
        we_d      = we_q;
        sel_d     = sel_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        err_d     = 1'b0;
        // A flush arriving on the ack/abort cycle itself also discards the result.
        drop_s    = discard_q | flush_i;
        case (state_q)
            ST_IDLE: begin
                if (mem_ce_i) begin
                    owner_d = OWN_MEM;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = mem_we_i;
                    sel_d   = mem_sel_i;
                    addr_d  = mem_addr_i;
                    wdata_d = mem_wdata_i;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_BUSY;
                end else if (if_ce_i) begin
                    owner_d = OWN_IF;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    we_d    = 1'b0;
                    sel_d   = 4'hF;
                    addr_d  = if_addr_i;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                discard_d = drop_s;
                if (bus_ack_i) begin
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    we_d      = 1'b0;
                    rd_buf_d  = we_q ? 32'h0000_0000 : bus_data_i;
                    cnt_d     = {CW{1'b0}};
                    discard_d = 1'b0;
                    state_d   = drop_s ? ST_IDLE : ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    cyc_d     = 1'b0;
                    stb_d     = 1'b0;
                    rd_buf_d  = 32'h0000_0000;
                    err_d     = 1'b1;
                    cnt_d     = {CW{1'b0}};
                    discard_d = 1'b0;
                    state_d   = drop_s ? ST_IDLE : ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: begin
                if ((stall_i == 6'b00_0000) || flush_i) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!Rst_n) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWN_IF;
            discard_q <= 1'b0;
            cnt_q     <= {CW{1'b0}};
            rd_buf_q  <= 32'h0000_0000;
            cyc_q     <= 1'b0;
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            sel_q     <= 4'h0;
            addr_q    <= 32'h0000_0000;
            wdata_q   <= 32'h0000_0000;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            discard_q <= discard_d;
            cnt_q     <= cnt_d;
            rd_buf_q  <= rd_buf_d;
            cyc_q     <= cyc_d;
            stb_q     <= stb_d;
            we_q      <= we_d;
            sel_q     <= sel_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
        end
    end

    assign bus_cyc_o  = cyc_q;
    assign bus_stb_o  = stb_q;
    assign bus_we_o   = we_q;
    assign bus_sel_o  = sel_q;
    assign bus_addr_o = addr_q;
    assign bus_data_o = wdata_q;
    assign bus_err_o  = err_q;

    assign if_rdata_o  = (owner_q == OWN_IF)  ? rd_buf_q : 32'h0000_0000;
    assign mem_rdata_o = (owner_q == OWN_MEM) ? rd_buf_q : 32'h0000_0000;

    assign if_stallreq_o  = if_ce_i  & ~((state_q == ST_DONE) & (owner_q == OWN_IF));
    assign mem_stallreq_o = mem_ce_i & ~((state_q == ST_DONE) & (owner_q == OWN_MEM));

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios with a scoreboard
// of expected read data per requesting port.
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [5:0]  stall = 6'b0;
    logic        flush = 1'b0;
    logic        if_ce = 1'b0;
    logic [31:0] if_addr = 32'h0;
    logic [31:0] if_rdata;
    logic        if_stallreq;
    logic        mem_ce = 1'b0;
    logic        mem_we = 1'b0;
    logic [3:0]  mem_sel = 4'h0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        mem_stallreq;
    logic        bus_cyc, bus_stb, bus_we, bus_err;
    logic [3:0]  bus_sel;
    logic [31:0] bus_addr, bus_dout;
    logic [31:0] bus_din = 32'h0;
    logic        bus_ack = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        port;   // 1 = MEM, 0 = IF
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    mem_bus_arbiter #(.TIMEOUT(16)) dut (
        .clk(clk), .Rst_n(rst_n), .stall_i(stall), .flush_i(flush),
        .if_ce_i(if_ce), .if_addr_i(if_addr), .if_rdata_o(if_rdata),
        .if_stallreq_o(if_stallreq),
        .mem_ce_i(mem_ce), .mem_we_i(mem_we), .mem_sel_i(mem_sel),
        .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata), .mem_rdata_o(mem_rdata),
        .mem_stallreq_o(mem_stallreq),
        .bus_cyc_o(bus_cyc), .bus_stb_o(bus_stb), .bus_we_o(bus_we),
        .bus_sel_o(bus_sel), .bus_addr_o(bus_addr), .bus_data_o(bus_dout),
        .bus_data_i(bus_din), .bus_ack_i(bus_ack), .bus_err_o(bus_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pop_exp(output exp_t e);
        if (sb.size() == 0) begin
            e.port = 1'b0;
            e.data = 32'hxxxx_xxxx;
        end else begin
            e = sb.pop_front();
        end
    endtask

    // Bounded wait for the bus cycle, then ack on the lat-th BUSY cycle.
    task automatic serve(input int lat, input logic [31:0] d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40 && !bus_cyc; i++) tick();
        if (bus_cyc) begin
            for (int k = 1; k < lat; k++) tick();
            bus_ack = 1'b1;
            bus_din = d;
            tick();
            bus_ack = 1'b0;
            bus_din = 32'h0;
            ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        checks++; if (bus_cyc !== 1'b0 || bus_stb !== 1'b0) begin errors++; $display("FAIL reset_cyc_stb: got %b%b expected 00", bus_cyc, bus_stb); end
        checks++; if (bus_addr !== 32'h0 || bus_sel !== 4'h0 || bus_we !== 1'b0) begin errors++; $display("FAIL reset_bus: got addr %h sel %h we %b expected 0", bus_addr, bus_sel, bus_we); end
        checks++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0 || bus_err !== 1'b0) begin errors++; $display("FAIL reset_rdata: got if %h mem %h err %b expected 0", if_rdata, mem_rdata, bus_err); end
    endtask

    task automatic test_single_fetch();
        exp_t e;
        int   n = 0;
        if_ce = 1'b1; if_addr = 32'h100; stall = 6'b00_0001;
        sb.push_back('{port: 1'b0, data: 32'h3C01_1234});
        #1; if (if_stallreq) n++;
        tick();
        checks++; if (bus_cyc !== 1'b1 || bus_stb !== 1'b1 || bus_addr !== 32'h100 || bus_sel !== 4'hF || bus_we !== 1'b0) begin errors++; $display("FAIL fetch_bus: got cyc %b stb %b addr %h sel %h we %b expected 1 1 100 f 0", bus_cyc, bus_stb, bus_addr, bus_sel, bus_we); end
        if (if_stallreq) n++;
        tick();
        bus_ack = 1'b1; bus_din = 32'h3C01_1234;
        #1; if (if_stallreq) n++;
        tick();
        bus_ack = 1'b0; bus_din = 32'h0;
        #1;
        checks++; if (if_stallreq !== 1'b0 || n != 3) begin errors++; $display("FAIL fetch_stallreq: got stallreq %b cycles %0d expected 0 after 3", if_stallreq, n); end
        pop_exp(e);
        checks++; if (if_rdata !== e.data || e.port !== 1'b0) begin errors++; $display("FAIL fetch_rdata: got %h expected %h", if_rdata, e.data); end
        checks++; if (bus_cyc !== 1'b0 || bus_stb !== 1'b0) begin errors++; $display("FAIL fetch_cyc_drop: got %b%b expected 00", bus_cyc, bus_stb); end
        tick();
        checks++; if (if_rdata !== 32'h3C01_1234 || if_stallreq !== 1'b0) begin errors++; $display("FAIL fetch_hold: got %h stallreq %b expected 3c011234 0", if_rdata, if_stallreq); end
        stall = 6'b0; if_ce = 1'b0;
        tick();
        if_ce = 1'b1; #1;
        checks++; if (if_stallreq !== 1'b1 || bus_cyc !== 1'b0) begin errors++; $display("FAIL fetch_idle: got stallreq %b cyc %b expected 1 0", if_stallreq, bus_cyc); end
        if_ce = 1'b0;
        tick();
    endtask

    task automatic test_collision();
        exp_t e;
        mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h2000;
        if_ce = 1'b1; if_addr = 32'h200; stall = 6'b00_0011;
        sb.push_back('{port: 1'b1, data: 32'h1111_2222});
        sb.push_back('{port: 1'b0, data: 32'h3333_4444});
        tick();
        checks++; if (bus_addr !== 32'h2000 || bus_we !== 1'b0 || if_stallreq !== 1'b1 || mem_stallreq !== 1'b1) begin errors++; $display("FAIL coll_mem_first: got addr %h we %b ifsr %b memsr %b expected 2000 0 1 1", bus_addr, bus_we, if_stallreq, mem_stallreq); end
        bus_ack = 1'b1; bus_din = 32'h1111_2222;
        tick();
        bus_ack = 1'b0; bus_din = 32'h0;
        pop_exp(e);
        checks++; if (mem_rdata !== e.data || e.port !== 1'b1 || mem_stallreq !== 1'b0 || if_stallreq !== 1'b1 || if_rdata !== 32'h0) begin errors++; $display("FAIL coll_mem_done: got mem %h memsr %b ifsr %b if %h expected %h 0 1 0", mem_rdata, mem_stallreq, if_stallreq, if_rdata, e.data); end
        mem_ce = 1'b0; stall = 6'b0;
        tick();
        checks++; if (bus_cyc !== 1'b0 || if_stallreq !== 1'b1) begin errors++; $display("FAIL coll_fresh_idle: got cyc %b ifsr %b expected 0 1", bus_cyc, if_stallreq); end
        stall = 6'b00_0001;
        tick();
        checks++; if (bus_cyc !== 1'b1 || bus_addr !== 32'h200 || bus_sel !== 4'hF || bus_we !== 1'b0) begin errors++; $display("FAIL coll_if_bus: got cyc %b addr %h sel %h we %b expected 1 200 f 0", bus_cyc, bus_addr, bus_sel, bus_we); end
        bus_ack = 1'b1; bus_din = 32'h3333_4444;
        tick();
        bus_ack = 1'b0; bus_din = 32'h0;
        pop_exp(e);
        checks++; if (if_rdata !== e.data || e.port !== 1'b0 || if_stallreq !== 1'b0 || mem_rdata !== 32'h0) begin errors++; $display("FAIL coll_if_done: got if %h ifsr %b mem %h expected %h 0 0", if_rdata, if_stallreq, mem_rdata, e.data); end
        if_ce = 1'b0; stall = 6'b0;
        tick();
    endtask

    task automatic test_store();
        exp_t e;
        mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'b0011; mem_wdata = 32'hDEAD_BEEF; mem_addr = 32'h40;
        stall = 6'b00_1000;
        sb.push_back('{port: 1'b1, data: 32'h0});
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (bus_cyc !== 1'b1 || bus_we !== 1'b1 || bus_sel !== 4'b0011 || bus_addr !== 32'h40 || bus_dout !== 32'hDEAD_BEEF) begin errors++; $display("FAIL store_bus: cycle %0d got cyc %b we %b sel %h addr %h data %h", i, bus_cyc, bus_we, bus_sel, bus_addr, bus_dout); end
        end
        bus_ack = 1'b1; bus_din = 32'h5555_5555;
        tick();
        bus_ack = 1'b0; bus_din = 32'h0;
        pop_exp(e);
        checks++; if (mem_rdata !== e.data || bus_we !== 1'b0 || bus_cyc !== 1'b0 || mem_stallreq !== 1'b0) begin errors++; $display("FAIL store_done: got rdata %h we %b cyc %b memsr %b expected %h 0 0 0", mem_rdata, bus_we, bus_cyc, mem_stallreq, e.data); end
        mem_ce = 1'b0; mem_we = 1'b0; stall = 6'b0;
        tick();
    endtask

    task automatic test_hold_stall();
        exp_t e;
        bit   ok;
        mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h80;
        stall = 6'b00_1111;
        sb.push_back('{port: 1'b1, data: 32'hCAFE_F00D});
        serve(1, 32'hCAFE_F00D, ok);
        checks++; if (!ok) begin errors++; $display("FAIL hold_serve: got no bus cycle expected one"); end
        pop_exp(e);
        for (int i = 0; i < 5; i++) begin
            checks++; if (mem_rdata !== e.data || mem_stallreq !== 1'b0) begin errors++; $display("FAIL hold_stable: cycle %0d got %h memsr %b expected %h 0", i, mem_rdata, mem_stallreq, e.data); end
            tick();
        end
        stall = 6'b0; mem_ce = 1'b0;
        tick();
        bus_ack = 1'b1; mem_ce = 1'b1; #1;
        checks++; if (mem_stallreq !== 1'b1 || bus_cyc !== 1'b0) begin errors++; $display("FAIL hold_idle: got memsr %b cyc %b expected 1 0", mem_stallreq, bus_cyc); end
        mem_ce = 1'b0;
        tick();
        bus_ack = 1'b0;
        checks++; if (bus_cyc !== 1'b0 || mem_rdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL idle_ack_ignored: got cyc %b rdata %h expected 0 cafef00d", bus_cyc, mem_rdata); end
    endtask

    task automatic test_timeout();
        exp_t e;
        int   n = 0;
        int   nerr = 0;
        if_ce = 1'b1; if_addr = 32'h300; stall = 6'b00_0001;
        sb.push_back('{port: 1'b0, data: 32'h0});
        tick();
        while (bus_cyc && n < 40) begin
            n++;
            if (bus_err) nerr++;
            tick();
        end
        checks++; if (n != 16) begin errors++; $display("FAIL timeout_len: got %0d busy cycles expected 16", n); end
        checks++; if (bus_err !== 1'b1 || bus_stb !== 1'b0) begin errors++; $display("FAIL timeout_err: got err %b stb %b expected 1 0", bus_err, bus_stb); end
        if (bus_err) nerr++;
        pop_exp(e);
        checks++; if (if_rdata !== e.data || if_stallreq !== 1'b0) begin errors++; $display("FAIL timeout_rdata: got %h ifsr %b expected %h 0", if_rdata, if_stallreq, e.data); end
        tick();
        if (bus_err) nerr++;
        checks++; if (nerr != 1) begin errors++; $display("FAIL timeout_pulse: got %0d err cycles expected 1", nerr); end
        if_ce = 1'b0; stall = 6'b0;
        tick();
    endtask

    task automatic test_flush();
        mem_ce = 1'b1; mem_we = 1'b0; mem_sel = 4'hF; mem_addr = 32'h500;
        stall = 6'b00_0001;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        tick();
        checks++; if (bus_cyc !== 1'b1 || bus_addr !== 32'h500) begin errors++; $display("FAIL flush_no_abort: got cyc %b addr %h expected 1 500", bus_cyc, bus_addr); end
        tick();
        bus_ack = 1'b1; bus_din = 32'h7777_7777;
        tick();
        bus_ack = 1'b0; bus_din = 32'h0;
        checks++; if (bus_cyc !== 1'b0 || mem_stallreq !== 1'b1) begin errors++; $display("FAIL flush_to_idle: got cyc %b memsr %b expected 0 1", bus_cyc, mem_stallreq); end
        mem_ce = 1'b0; stall = 6'b0;
        tick();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL sb_empty: got %0d pending expected 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   ok;
        mem_ce = 1'b1; mem_we = 1'b1; mem_sel = 4'b1100; mem_addr = 32'h600; mem_wdata = 32'h1234_5678;
        stall = 6'b00_0001;
        tick();
        checks++; if (bus_cyc !== 1'b1 || bus_we !== 1'b1) begin errors++; $display("FAIL rstmid_busy: got cyc %b we %b expected 1 1", bus_cyc, bus_we); end
        rst_n = 1'b0; mem_ce = 1'b0; mem_we = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++; if (bus_cyc !== 1'b0 || bus_stb !== 1'b0 || bus_we !== 1'b0 || bus_sel !== 4'h0 || bus_addr !== 32'h0 || bus_dout !== 32'h0) begin errors++; $display("FAIL rstmid_bus: got cyc %b stb %b we %b sel %h addr %h data %h expected all 0", bus_cyc, bus_stb, bus_we, bus_sel, bus_addr, bus_dout); end
        checks++; if (if_rdata !== 32'h0 || mem_rdata !== 32'h0 || bus_err !== 1'b0) begin errors++; $display("FAIL rstmid_out: got if %h mem %h err %b expected 0", if_rdata, mem_rdata, bus_err); end
        if_ce = 1'b1; if_addr = 32'h700;
        sb.push_back('{port: 1'b0, data: 32'hA5A5_0F0F});
        serve(1, 32'hA5A5_0F0F, ok);
        pop_exp(e);
        checks++; if (!ok || if_rdata !== e.data || if_stallreq !== 1'b0) begin errors++; $display("FAIL rstmid_after: got ok %b rdata %h ifsr %b expected 1 %h 0", ok, if_rdata, if_stallreq, e.data); end
        if_ce = 1'b0; stall = 6'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_collision();
        test_store();
        test_hold_stall();
        test_timeout();
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one Wishbone-style single-port memory bus between the instruction-fetch port (IF) and the load/store port (MEM stage) of the 5-stage pipeline.
- Raises per-port stall requests to the pipeline stall controller until the bus returns data.
- Holds the returned data stable while the pipeline is frozen through the 6-bit stall vector.
- Sits between the IF/MEM stages and external memory.

Parameters:
- TIMEOUT, 16, max cycles a bus transaction waits for ack before abort (>=2).

Ports:
- clk  in  1  clock, rising edge
- Rst_n  in  1  reset, synchronous, active-low
- stall_i  in  6  pipeline stall vector from stall controller
- flush_i  in  1  pipeline flush (exception)
- if_ce_i  in  1  instruction fetch request
- if_addr_i  in  32  fetch address
- if_rdata_o  out  32  fetched instruction
- if_stallreq_o  out  1  IF stall request
- mem_ce_i  in  1  load/store request
- mem_we_i  in  1  1=store
- mem_sel_i  in  4  byte enables
- mem_addr_i  in  32  data address
- mem_wdata_i  in  32  store data
- mem_rdata_o  out  32  load data
- mem_stallreq_o  out  1  MEM stall request
- bus_cyc_o, bus_stb_o  out  1 each  bus cycle/strobe
- bus_we_o  out  1  bus write
- bus_sel_o  out  4  bus byte enables
- bus_addr_o  out  32  bus address
- bus_data_o  out  32  bus write data
- bus_data_i  in  32  bus read data
- bus_ack_i  in  1  bus acknowledge
- bus_err_o  out  1  one-cycle pulse on timeout abort

Behaviour:
- Reset (Rst_n=0 at clk edge): state=IDLE, owner=IF, discard=0, timeout counter=0, rd_buf=0. All bus_* outputs=0; if_rdata_o=0; mem_rdata_o=0; bus_err_o=0. Overrides every other input, including mid-transaction; the in-flight bus cycle is dropped.
- States: IDLE, BUSY, DONE. owner register selects IF or MEM.
- IDLE:
  - mem_ce_i=1: owner=MEM; register bus_cyc/stb=1, we=mem_we_i, sel=mem_sel_i, addr=mem_addr_i, data=mem_wdata_i; go BUSY.
  - Else if_ce_i=1: owner=IF, we=0, sel=4'hF, addr=if_addr_i; go BUSY.
  - MEM has fixed priority over IF on simultaneous requests.
  - flush_i ignored in IDLE.
- BUSY:
  - Bus outputs held constant; counter increments each cycle.
  - bus_ack_i=1: next edge clears cyc/stb/we; rd_buf=bus_data_i (0 if write); counter=0.
    - discard=1: go IDLE, discard=0.
    - Else: go DONE.
  - Counter reaches TIMEOUT-1 with no ack: clear cyc/stb, rd_buf=0, bus_err_o=1 for one cycle, go DONE (IDLE if discard).
  - flush_i=1 sets discard=1. The bus cycle is never aborted by flush.
- DONE:
  - Requester data valid.
  - Return to IDLE when stall_i==6'b0 or flush_i=1.
  - Otherwise hold rd_buf indefinitely.
- Read data:
  - mem_rdata_o = rd_buf when owner=MEM, else 0.
  - if_rdata_o = rd_buf when owner=IF, else 0.
  - Both are combinational from registered state.
- Stall requests (combinational):
  - if_stallreq_o = if_ce_i & ~(state==DONE & owner==IF).
  - mem_stallreq_o = mem_ce_i & ~(state==DONE & owner==MEM).
  - A port waiting behind the other owner keeps its stallreq high.
- Latency: zero-wait-state slave (ack in the first BUSY cycle) gives request edge -> BUSY, ack edge -> DONE. stallreq is high for 2 cycles.
- Back-to-back: after DONE->IDLE a new request needs a fresh IDLE cycle. There is no bypass from DONE directly to BUSY.
- bus_ack_i outside BUSY is ignored.

Test Plan:
- Single fetch: if_ce=1, addr=0x100, ack after 2 cycles with data 0x3C011234 -> addr 0x100 on bus, sel=F, we=0; if_stallreq high 3 cycles; if_rdata_o=0x3C011234 in DONE; IDLE once stall_i=0.
- Collision: if_ce and mem_ce both 1 in IDLE, load addr 0x2000 -> MEM served first, if_stallreq stays high; IF transaction starts in the IDLE cycle after MEM completes.
- Store: mem_we=1, sel=4'b0011, wdata=0xDEADBEEF, addr=0x40 -> bus carries exactly those values until ack; mem_rdata_o=0.
- Hold under stall: complete load returning 0xCAFEF00D with stall_i=6'b001111 held 5 cycles -> mem_rdata_o stable at 0xCAFEF00D, mem_stallreq_o=0; IDLE when stall_i=0.
- Timeout: TIMEOUT=16, no ack -> cyc/stb drop after 16 BUSY cycles; bus_err_o pulses once; rd_buf=0.
- Flush/reset mid-op:
  - flush in BUSY, ack 3 cycles later -> IDLE directly, no DONE.
  - Rst_n=0 in BUSY -> all outputs 0 next edge.
